// File: rtl/phoenix_switch_control_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : phoenix_switch_control_pkg                                       |
// | Purpose : Shared constants for the phoenix router switch controller:       |
// |           port count, port indices and FSM state codes.                    |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package phoenix_switch_control_pkg;

  localparam int NPORT = 5;

  // Port indices; also the encoding used in the mux_in / mux_out tables.
  localparam logic [2:0] EAST  = 3'd0;
  localparam logic [2:0] WEST  = 3'd1;
  localparam logic [2:0] NORTH = 3'd2;
  localparam logic [2:0] SOUTH = 3'd3;
  localparam logic [2:0] LOCAL = 3'd4;

  // Controller FSM state codes.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARB   = 3'd1;
  localparam logic [2:0] S_ROUTE = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_GRANT = 3'd4;

endpackage
`default_nettype wire

// File: rtl/phoenix_switch_control_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : phoenix_switch_control_rr_arbiter                                |
// | Purpose : Combinational 5-way round-robin select. The search starts at     |
// |           ptr+1 (mod NPORT) and returns the first requesting index.        |
// | Ports   : req   in  NPORT  pending requests                                |
// |           ptr   in  3      index granted last time                         |
// |           grant out 3      selected index (ptr when nothing requests)      |
// |           valid out 1      at least one request present                    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module phoenix_switch_control_rr_arbiter
  import phoenix_switch_control_pkg::*;
(
  input  logic [NPORT-1:0] req,
  input  logic [2:0]       ptr,
  output logic [2:0]       grant,
  output logic             valid
);

  logic [2:0] w_idx;

  // Walk the candidates from farthest to nearest so the nearest requester
  // after ptr is the last one written and therefore wins.
  always_comb begin
    grant = ptr;
    valid = 1'b0;
    w_idx = ptr;
    for (int i = NPORT; i >= 1; i--) begin
      w_idx = 3'((int'(ptr) + i) % NPORT);
      if (req[w_idx]) begin
        grant = w_idx;
        valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/phoenix_switch_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : phoenix_switch_control                                           |
// | Purpose : Routing/arbitration controller for the five router input ports.  |
// |           Picks a pending header round-robin, computes its XY route,       |
// |           grants it when the target output is free, keeps the crossbar     |
// |           connection tables and releases a connection when the owning      |
// |           buffer's sender falls.                                           |
// | Ports   : clock, reset (sync, active-high)                                 |
// |           address  in  ADDR_W          this router's {x,y}                 |
// |           h        in  NPORT           per-input routing request           |
// |           sender   in  NPORT           per-input connection in use         |
// |           data_in  in  NPORT*TAM_FLIT  per-input buffer head               |
// |           ack_h    out NPORT           one-hot one-cycle routing grant     |
// |           out_busy out NPORT           output allocated                    |
// |           in_conn  out NPORT           input connected                     |
// |           mux_in   out NPORT*3         per output: source input index      |
// |           mux_out  out NPORT*3         per input: destination output index |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module phoenix_switch_control
  import phoenix_switch_control_pkg::*;
#(
  parameter int TAM_FLIT = 16,
  parameter int ADDR_W   = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         address,
  input  logic [NPORT-1:0]          h,
  input  logic [NPORT-1:0]          sender,
  input  logic [NPORT*TAM_FLIT-1:0] data_in,
  output logic [NPORT-1:0]          ack_h,
  output logic [NPORT-1:0]          out_busy,
  output logic [NPORT-1:0]          in_conn,
  output logic [NPORT*3-1:0]        mux_in,
  output logic [NPORT*3-1:0]        mux_out
);

  localparam int HALF = ADDR_W / 2;

  logic [2:0]         r_state;
  logic [2:0]         r_sel;
  logic [2:0]         r_dest;
  logic [2:0]         r_rr;
  logic [NPORT-1:0]   r_out_busy;
  logic [NPORT-1:0]   r_in_conn;
  logic [NPORT-1:0]   r_sender_d;
  logic [NPORT*3-1:0] r_mux_in;
  logic [NPORT*3-1:0] r_mux_out;

  logic [NPORT-1:0]   w_req;
  logic [2:0]         w_arb_grant;
  logic               w_arb_valid;
  logic [ADDR_W-1:0]  w_target;
  logic [NPORT-1:0]   w_release;
  logic [NPORT-1:0]   w_busy_nxt;
  logic [NPORT-1:0]   w_conn_nxt;

  // Only the low ADDR_W bits of each head carry the target address.
  logic w_unused_data_in;
  assign w_unused_data_in = ^data_in;

  // Unsigned XY routing: X is resolved first, then Y.
  function automatic logic [2:0] xy_route(input logic [ADDR_W-1:0] target,
                                          input logic [ADDR_W-1:0] here);
    logic [HALF-1:0] tx, ty, lx, ly;
    tx = target[ADDR_W-1:HALF];
    ty = target[HALF-1:0];
    lx = here[ADDR_W-1:HALF];
    ly = here[HALF-1:0];
    if (tx > lx)      return EAST;
    else if (tx < lx) return WEST;
    else if (ty > ly) return NORTH;
    else if (ty < ly) return SOUTH;
    else              return LOCAL;
  endfunction

  // Connected inputs do not compete for a new route.
  assign w_req = h & ~r_in_conn;

  phoenix_switch_control_rr_arbiter u_arb (
    .req   (w_req),
    .ptr   (r_rr),
    .grant (w_arb_grant),
    .valid (w_arb_valid)
  );

  assign w_target = data_in[int'(r_sel)*TAM_FLIT +: ADDR_W];

  // A connection ends on the falling edge of its buffer's sender.
  assign w_release = r_in_conn & r_sender_d & ~sender;

  // Release is applied before the grant; the two always concern different
  // ports, because CHECK judged the granted output on pre-release state.
  always_comb begin
    w_busy_nxt = r_out_busy;
    w_conn_nxt = r_in_conn;
    for (int p = 0; p < NPORT; p++) begin
      if (w_release[p]) begin
        w_conn_nxt[p]                   = 1'b0;
        w_busy_nxt[r_mux_out[p*3 +: 3]] = 1'b0;
      end
    end
    if (r_state == S_GRANT) begin
      w_busy_nxt[r_dest] = 1'b1;
      w_conn_nxt[r_sel]  = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_sel      <= EAST;
      r_dest     <= EAST;
      r_rr       <= LOCAL;
      r_out_busy <= '0;
      r_in_conn  <= '0;
      r_sender_d <= '0;
      r_mux_in   <= '0;
      r_mux_out  <= '0;
    end else begin
      r_sender_d <= sender;
      r_out_busy <= w_busy_nxt;
      r_in_conn  <= w_conn_nxt;
      case (r_state)
        S_IDLE: begin
          if (|w_req) r_state <= S_ARB;
        end
        S_ARB: begin
          if (w_arb_valid) begin
            r_sel   <= w_arb_grant;
            r_rr    <= w_arb_grant;
            r_state <= S_ROUTE;
          end else begin
            // Unreachable by the IDLE entry condition; abandon the pass.
            r_sel   <= r_rr;
            r_state <= S_IDLE;
          end
        end
        S_ROUTE: begin
          r_dest  <= xy_route(w_target, address);
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          // A busy target drops back to IDLE; the request is retried on a
          // later pass once the pointer has moved on.
          r_state <= r_out_busy[r_dest] ? S_IDLE : S_GRANT;
        end
        S_GRANT: begin
          r_mux_in[int'(r_dest)*3 +: 3] <= r_sel;
          r_mux_out[int'(r_sel)*3 +: 3] <= r_dest;
          r_state                       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ack_h = '0;
    if (r_state == S_GRANT) ack_h[r_sel] = 1'b1;
  end

  assign out_busy = r_out_busy;
  assign in_conn  = r_in_conn;
  assign mux_in   = r_mux_in;
  assign mux_out  = r_mux_out;

endmodule
`default_nettype wire

// File: tb/tb_phoenix_switch_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_phoenix_switch_control                                        |
// | Purpose : Directed self-checking bench for phoenix_switch_control.         |
// | Ports   : none                                                             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_phoenix_switch_control;

  localparam int NP = 5;
  localparam int TF = 16;

  logic             clock;
  logic             reset;
  logic [7:0]       address;
  logic [NP-1:0]    h;
  logic [NP-1:0]    sender;
  logic [NP*TF-1:0] data_in;
  logic [NP-1:0]    ack_h;
  logic [NP-1:0]    out_busy;
  logic [NP-1:0]    in_conn;
  logic [NP*3-1:0]  mux_in;
  logic [NP*3-1:0]  mux_out;

  int n_cmp = 0;
  int n_err = 0;

  phoenix_switch_control #(.TAM_FLIT(TF), .ADDR_W(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .address  (address),
    .h        (h),
    .sender   (sender),
    .data_in  (data_in),
    .ack_h    (ack_h),
    .out_busy (out_busy),
    .in_conn  (in_conn),
    .mux_in   (mux_in),
    .mux_out  (mux_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    h      = '0;
    sender = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic set_head(input int p, input logic [15:0] v);
    data_in[p*TF +: TF] = v;
  endtask

  // Routing table for a single request from NORTH: target -> expected output.
  logic [7:0] route_tgt [5] = '{8'h30, 8'h03, 8'h1F, 8'hF0, 8'h00};
  logic [2:0] route_exp [5] = '{3'd0,  3'd1,  3'd2,  3'd0,  3'd1};

  initial begin
    logic seen;
    logic got;
    logic [4:0] exp_ack;

    reset   = 1'b1;
    address = 8'h11;
    h       = '0;
    sender  = '0;
    data_in = '0;
    do_reset();

    // Reset state
    check("rst_ack",      ack_h,    0);
    check("rst_busy",     out_busy, 0);
    check("rst_conn",     in_conn,  0);
    check("rst_mux_in",   mux_in,   0);
    check("rst_mux_out",  mux_out,  0);

    // 1: EAST request to x=3 -> EAST output, ack 4 cycles after h
    set_head(0, 16'h0032);
    h = 5'b00001;
    step(); step(); step();
    check("t1_ack_early", ack_h, 0);
    step();
    check("t1_ack", ack_h, 5'b00001);
    h = '0;
    sender = 5'b00001;
    step();
    check("t1_ack_one_cycle", ack_h,        0);
    check("t1_busy",          out_busy,     5'b00001);
    check("t1_conn",          in_conn,      5'b00001);
    check("t1_mux_in_e",      mux_in[2:0],  3'd0);
    check("t1_mux_out_e",     mux_out[2:0], 3'd0);

    // 2: WEST wants EAST while it is busy; retried after EAST's sender falls
    set_head(1, 16'h0032);
    h = 5'b00010;
    seen = 1'b0;
    repeat (12) begin
      step();
      if (ack_h != 0) seen = 1'b1;
    end
    check("t2_no_ack_busy", seen, 0);
    sender = '0;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      step();
      if (ack_h == 5'b00010) got = 1'b1;
    end
    check("t2_retry_ack", got, 1);
    h = '0;
    step();
    check("t2_busy",      out_busy,     5'b00001);
    check("t2_conn",      in_conn,      5'b00010);
    check("t2_mux_in_e",  mux_in[2:0],  3'd1);
    check("t2_mux_out_w", mux_out[5:3], 3'd0);

    // 3+4: all five request distinct outputs; grants E,W,N,S,L 5 cycles apart
    do_reset();
    set_head(0, 16'h0011);   // LOCAL
    set_head(1, 16'h0010);   // SOUTH
    set_head(2, 16'h0001);   // WEST
    set_head(3, 16'h0012);   // NORTH
    set_head(4, 16'h0032);   // EAST
    h = 5'b11111;
    for (int i = 1; i <= 25; i++) begin
      step();
      exp_ack = (i % 5 == 4) ? 5'(1 << ((i - 4) / 5)) : 5'b0;
      check($sformatf("t3_ack_c%0d", i), ack_h, exp_ack);
    end
    check("t3_busy",    out_busy, 5'b11111);
    check("t3_conn",    in_conn,  5'b11111);
    check("t3_mux_out", mux_out,  {3'd0, 3'd2, 3'd1, 3'd3, 3'd4});
    check("t3_mux_in",  mux_in,   {3'd0, 3'd1, 3'd3, 3'd2, 3'd4});

    // 4b: X has priority over Y, comparisons unsigned
    for (int k = 0; k < 5; k++) begin
      do_reset();
      set_head(2, {8'h00, route_tgt[k]});
      h = 5'b00100;
      repeat (4) step();
      check($sformatf("t4_ack_%0h", route_tgt[k]), ack_h, 5'b00100);
      h = '0;
      step();
      check($sformatf("t4_route_%0h", route_tgt[k]), mux_out[8:6], route_exp[k]);
    end

    // 5: N->E released in the same cycle S->E is in CHECK: retried next pass
    do_reset();
    set_head(2, 16'h0032);
    h = 5'b00100;
    repeat (4) step();
    check("t5_ack_n", ack_h, 5'b00100);
    h = '0;
    sender = 5'b00100;
    repeat (3) step();
    set_head(3, 16'h0032);
    h = 5'b01000;
    repeat (3) step();             // now in CHECK for SOUTH
    check("t5_ack_pre", ack_h, 0);
    sender = '0;
    step();
    check("t5_ack_release_cycle", ack_h,    0);
    check("t5_busy_released",     out_busy, 0);
    check("t5_conn_released",     in_conn,  0);
    repeat (3) step();
    check("t5_ack_before_retry", ack_h, 0);
    step();
    check("t5_ack_s", ack_h, 5'b01000);
    h = '0;
    step();
    check("t5_busy",     out_busy,    5'b00001);
    check("t5_mux_in_e", mux_in[2:0], 3'd3);

    // 6: reset asserted during GRANT clears everything; no ack afterwards
    set_head(1, 16'h0001);
    h = 5'b00010;
    repeat (4) step();
    check("t6_ack_w", ack_h, 5'b00010);
    reset = 1'b1;
    step();
    reset = 1'b0;
    h = '0;
    check("t6_ack",     ack_h,    0);
    check("t6_busy",    out_busy, 0);
    check("t6_conn",    in_conn,  0);
    check("t6_mux_in",  mux_in,   0);
    check("t6_mux_out", mux_out,  0);
    seen = 1'b0;
    repeat (8) begin
      step();
      if (ack_h != 0) seen = 1'b1;
    end
    check("t6_no_ack_after", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
